// File: rtl/irq_ctrl_pkg.sv
// Shared constants and state encoding for the interrupt controller.
package irq_ctrl_pkg;

  localparam int DEF_N_SRC = 8;
  localparam int DEF_ID_W  = 3;

  localparam logic [1:0] IRQ_ST_IDLE    = 2'd0;
  localparam logic [1:0] IRQ_ST_REQ     = 2'd1;
  localparam logic [1:0] IRQ_ST_SERVICE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = IRQ_ST_IDLE,
    S_REQ     = IRQ_ST_REQ,
    S_SERVICE = IRQ_ST_SERVICE
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest set index wins, index is 0 when nothing is set.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downward so the lowest set bit is the last (winning) assignment.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches source events, masks, prioritises and requests the core.
// Define IRQ_CTRL_LEVEL_EN for level-sensitive sources (pending mirrors the registered inputs).
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int               N_SRC    = DEF_N_SRC,
  parameter int               ID_W     = DEF_ID_W,
  parameter logic [N_SRC-1:0] MASK_RST = {N_SRC{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_src,
  input  logic             i_mask_we,
  input  logic [N_SRC-1:0] i_mask_wdata,
  input  logic             i_ack,
  input  logic             i_eret,
  output logic             o_irq,
  output logic [ID_W-1:0]  o_irq_id,
  output logic [N_SRC-1:0] o_pending,
  output logic [N_SRC-1:0] o_mask
);

  irq_state_e       state_reg, state_next;
  logic [N_SRC-1:0] src_q_reg;
  logic [N_SRC-1:0] mask_reg;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] cand;
  logic [ID_W-1:0]  id_reg, id_next;
  logic             enc_valid;
  logic [ID_W-1:0]  enc_id;
  logic             take_ack;

  assign take_ack = (state_reg == S_REQ) && i_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      src_q_reg <= '0;
      mask_reg  <= MASK_RST;
    end else begin
      src_q_reg <= i_src;
      if (i_mask_we) mask_reg <= i_mask_wdata;
    end
  end

`ifdef IRQ_CTRL_LEVEL_EN
  assign pending = src_q_reg;
`else
  logic [N_SRC-1:0] pending_reg, pending_next;

  always_comb begin
    pending_next = pending_reg;
    if (take_ack) pending_next[id_reg] = 1'b0;
    // Applied after the ack clear so a same-cycle event keeps the bit set.
    pending_next = pending_next | (i_src & ~src_q_reg);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) pending_reg <= '0;
    else       pending_reg <= pending_next;
  end

  assign pending = pending_reg;
`endif

  assign cand = pending & mask_reg;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (cand),
    .valid (enc_valid),
    .idx   (enc_id)
  );

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    case (state_reg)
      S_IDLE: begin
        id_next = enc_id;
        if (enc_valid) state_next = S_REQ;
      end
      S_REQ: begin
        if (i_ack) begin
          state_next = S_SERVICE;
        end else begin
          id_next = enc_id;
          if (!enc_valid) state_next = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (i_eret) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        id_next    = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
    end
  end

  assign o_irq     = (state_reg == S_REQ);
  assign o_irq_id  = id_reg;
  assign o_pending = pending;
  assign o_mask    = mask_reg;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; the level-sensitive build runs its own short sequence.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       ack;
  logic       eret;
  logic       irq;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] mask;

  int n_checks = 0;
  int n_errors = 0;

  irq_controller dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_src        (src),
    .i_mask_we    (mask_we),
    .i_mask_wdata (mask_wdata),
    .i_ack        (ack),
    .i_eret       (eret),
    .o_irq        (irq),
    .o_irq_id     (irq_id),
    .o_pending    (pending),
    .o_mask       (mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we = 1'b1; mask_wdata = m;
    step();
    mask_we = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1; step(); eret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; eret = 1'b0;
    step(); step();
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_pending", 32'(pending), 32'h00);
    chk("rst_mask", 32'(mask), 32'hFF);
    rst = 1'b0;
    step();

`ifdef IRQ_CTRL_LEVEL_EN
    src = 8'h01; step();
    chk("lvl_pending", 32'(pending), 32'h01);
    chk("lvl_irq_wait", 32'(irq), 32'd0);
    step();
    chk("lvl_irq", 32'(irq), 32'd1);
    chk("lvl_id", 32'(irq_id), 32'd0);
    do_ack();
    chk("lvl_ack_irq", 32'(irq), 32'd0);
    chk("lvl_ack_pending", 32'(pending), 32'h01);
    step();
    chk("lvl_service_irq", 32'(irq), 32'd0);
    do_eret();
    chk("lvl_eret_irq", 32'(irq), 32'd0);
    step();
    chk("lvl_reenter_irq", 32'(irq), 32'd1);
    src = 8'h00; step();
    chk("lvl_drop_pending", 32'(pending), 32'h00);
    chk("lvl_drop_irq_hold", 32'(irq), 32'd1);
    step();
    chk("lvl_drop_irq", 32'(irq), 32'd0);
`else
    // 1: single event on source 4
    src = 8'h10; step(); src = 8'h00;
    chk("t1_pending", 32'(pending), 32'h10);
    chk("t1_irq_early", 32'(irq), 32'd0);
    step();
    chk("t1_irq", 32'(irq), 32'd1);
    chk("t1_id", 32'(irq_id), 32'd4);
    do_ack();
    chk("t1_ack_irq", 32'(irq), 32'd0);
    chk("t1_ack_pending", 32'(pending), 32'h00);
    step();
    chk("t1_service_irq", 32'(irq), 32'd0);
    do_eret(); step();
    chk("t1_idle_irq", 32'(irq), 32'd0);

    // 2: simultaneous sources 5 and 2
    src = 8'h24; step(); src = 8'h00; step();
    chk("t2_irq", 32'(irq), 32'd1);
    chk("t2_id", 32'(irq_id), 32'd2);
    do_ack();
    chk("t2_ack_pending", 32'(pending), 32'h20);
    chk("t2_service_id", 32'(irq_id), 32'd2);
    do_eret();
    chk("t2_eret_irq", 32'(irq), 32'd0);
    step();
    chk("t2_reirq", 32'(irq), 32'd1);
    chk("t2_reid", 32'(irq_id), 32'd5);
    do_ack(); do_eret();

    // 3: masking
    write_mask(8'hFB);
    chk("t3_mask", 32'(mask), 32'hFB);
    src = 8'h04; step(); src = 8'h00;
    chk("t3_pending", 32'(pending), 32'h04);
    step();
    chk("t3_masked_irq", 32'(irq), 32'd0);
    chk("t3_masked_id", 32'(irq_id), 32'd0);
    write_mask(8'hFF);
    chk("t3_unmask_irq_wait", 32'(irq), 32'd0);
    step();
    chk("t3_unmask_irq", 32'(irq), 32'd1);
    chk("t3_unmask_id", 32'(irq_id), 32'd2);
    write_mask(8'hFB);
    chk("t3_remask_irq_hold", 32'(irq), 32'd1);
    step();
    chk("t3_remask_drop", 32'(irq), 32'd0);
    write_mask(8'hFF); step();
    chk("t3_restore_irq", 32'(irq), 32'd1);
    do_ack(); do_eret();

    // 4: event collides with ack of the same source; ack ignored in IDLE
    src = 8'h08; step(); src = 8'h00; step();
    chk("t4_id", 32'(irq_id), 32'd3);
    src = 8'h08; ack = 1'b1; step(); src = 8'h00; ack = 1'b0;
    chk("t4_collide_pending", 32'(pending), 32'h08);
    chk("t4_collide_irq", 32'(irq), 32'd0);
    step(); do_eret(); step();
    chk("t4_again_irq", 32'(irq), 32'd1);
    chk("t4_again_id", 32'(irq_id), 32'd3);
    do_ack(); do_eret();
    write_mask(8'h00);
    src = 8'h01; step(); src = 8'h00;
    do_ack();
    chk("t4_idle_ack_pending", 32'(pending), 32'h01);
    chk("t4_idle_ack_irq", 32'(irq), 32'd0);
    write_mask(8'hFF); step();
    chk("t4_late_irq", 32'(irq), 32'd1);
    chk("t4_late_id", 32'(irq_id), 32'd0);
    do_ack(); do_eret();

    // 5: service blocking, then reset while requesting
    src = 8'h40; step(); src = 8'h00; step(); do_ack();
    src = 8'h02; step(); src = 8'h00;
    chk("t5_svc_pending", 32'(pending), 32'h02);
    chk("t5_svc_irq", 32'(irq), 32'd0);
    step();
    chk("t5_svc_irq2", 32'(irq), 32'd0);
    chk("t5_svc_id_frozen", 32'(irq_id), 32'd6);
    do_eret();
    chk("t5_eret_irq", 32'(irq), 32'd0);
    step();
    chk("t5_irq", 32'(irq), 32'd1);
    chk("t5_id", 32'(irq_id), 32'd1);
    write_mask(8'h0F);
    chk("t5_mask_req", 32'(mask), 32'h0F);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_rst_irq", 32'(irq), 32'd0);
    chk("t5_rst_id", 32'(irq_id), 32'd0);
    chk("t5_rst_pending", 32'(pending), 32'h00);
    chk("t5_rst_mask", 32'(mask), 32'hFF);
    step();
    chk("t5_post_rst_irq", 32'(irq), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
